multicycle_control_unit: RTL and testbench

- Next-generation MIPS control unit: replaces the single-cycle op/func decoder with a registered multi-cycle FSM.
- Sequences each instruction through fetch, decode, execute, memory and write-back steps, and drives per-cycle datapath enables.
- Stalls on a memory-ready handshake and traps on illegal encodings.
- Sits between the instruction register and the multi-cycle datapath: PC, IR, register file, ALU and unified memory.

---
 rtl/multicycle_control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//
// Registered multi-cycle MIPS control FSM. It steps each instruction through
// fetch / decode / execute / memory / write-back states and drives the
// datapath enables and selects for the current step. Memory states stall on
// mem_ready (when USE_MEM_READY = 1). Unsupported encodings park the FSM in
// TRAP with a sticky illegal flag until reset.
//
// Optional feature: define MCU_JUMP_EN to decode op 000010 (j) to the JUMP
// state. Without it, j is treated as illegal and pc_source never drives 10.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   op, func      in   opcode and function field from the IR
//   mem_ready     in   memory access completes this cycle
//   pc_write      out  unconditional PC load
//   pc_write_cond out  PC load if ALU zero (beq)
//   i_or_d        out  memory address select: 0 = PC, 1 = ALUOut
//   mem_read      out  memory read strobe
//   mem_write     out  memory write strobe
//   ir_write      out  IR load
//   reg_dst       out  write register: 0 = rt, 1 = rd
//   mem_to_reg    out  write data: 0 = ALUOut, 1 = MDR
//   reg_write     out  register file write
//   alu_src_a     out  ALU A: 0 = PC, 1 = rs
//   alu_src_b     out  ALU B: 00 = rt, 01 = 4, 10 = sext imm, 11 = imm<<2
//   pc_source     out  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target
//   alu_op        out  ALU operation code
//   illegal       out  sticky illegal-instruction flag
//   state         out  current state (debug)
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int unsigned OP_W          = 6,
    parameter int unsigned FUNC_W        = 6,
    parameter int unsigned ALU_OP_W      = 3,
    parameter int unsigned STATE_W       = 4,
    parameter int unsigned USE_MEM_READY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNC_W-1:0]   func,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StIExec  = 4'd9,
        StIwb    = 4'd10,
        StJump   = 4'd11,
        StTrap   = 4'd12
    } state_e;

    localparam logic [OP_W-1:0] OpR    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OpLw   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OpSw   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OpBeq  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OpAddi = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OpOri  = OP_W'(6'b001101);
`ifdef MCU_JUMP_EN
    localparam logic [OP_W-1:0] OpJ    = OP_W'(6'b000010);
`endif

    localparam logic [FUNC_W-1:0] FnAdd = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] FnSub = FUNC_W'(6'b100010);
    localparam logic [FUNC_W-1:0] FnAnd = FUNC_W'(6'b100100);
    localparam logic [FUNC_W-1:0] FnOr  = FUNC_W'(6'b100101);
    localparam logic [FUNC_W-1:0] FnSlt = FUNC_W'(6'b101010);

    localparam logic [ALU_OP_W-1:0] AluAnd = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] AluOr  = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] AluAdd = ALU_OP_W'(3'b010);
    localparam logic [ALU_OP_W-1:0] AluSub = ALU_OP_W'(3'b110);
    localparam logic [ALU_OP_W-1:0] AluSlt = ALU_OP_W'(3'b111);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_rdy;

    // R-type function decode
    logic                func_legal;
    logic [ALU_OP_W-1:0] func_alu_op;

    // With the handshake disabled, every memory access completes in one cycle.
    assign mem_rdy = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;

    always_comb begin
        func_legal  = 1'b1;
        func_alu_op = AluAdd;
        case (func)
            FnAdd:   func_alu_op = AluAdd;
            FnSub:   func_alu_op = AluSub;
            FnAnd:   func_alu_op = AluAnd;
            FnOr:    func_alu_op = AluOr;
            FnSlt:   func_alu_op = AluSlt;
            default: func_legal  = 1'b0;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_rdy) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw:    state_d = StMemAdr;
                    OpR:           state_d = func_legal ? StExec : StTrap;
                    OpBeq:         state_d = StBranch;
                    OpAddi, OpOri: state_d = StIExec;
`ifdef MCU_JUMP_EN
                    OpJ:           state_d = StJump;
`endif
                    default:       state_d = StTrap;
                endcase
            end
            StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_rdy) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_rdy) state_d = StFetch;
            StExec:   state_d = StRwb;
            StRwb:    state_d = StFetch;
            StBranch: state_d = StFetch;
            StIExec:  state_d = StIwb;
            StIwb:    state_d = StFetch;
            StJump:   state_d = StFetch;
            StTrap:   state_d = StTrap;
            // Unused encodings recover to fetch without flagging illegal.
            default:  state_d = StFetch;
        endcase
    end

    // Sticky: set on entry to TRAP so it is visible alongside state = TRAP.
    assign illegal_d = illegal_q | (state_d == StTrap);

    // ---------------- output logic ----------------
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = AluAnd;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = AluAdd;
                // IR and PC load only once the instruction word is valid.
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                alu_op    = AluAdd;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = AluAdd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = func_alu_op;
            end
            StRwb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op == OpOri) ? AluOr : AluAdd;
            end
            StIwb: begin
                reg_write = 1'b1;
                // ALU result path kept stable through write-back.
                alu_op    = (op == OpOri) ? AluOr : AluAdd;
            end
            StJump: begin
`ifdef MCU_JUMP_EN
                pc_write  = 1'b1;
                pc_source = 2'b10;
`endif
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for multicycle_control_unit. Each cycle applies op/func/
// mem_ready after the falling edge and compares state, the packed control
// vector and illegal against hand-written expected values.
// Control vector order:
//   {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
//    mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], pc_source[1:0],
//    alu_op[2:0]}
// ----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [16:0] ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_ill = 1'b0;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpBad  = 6'b111111;
    localparam logic [5:0] FnSlt  = 6'b101010;

    localparam logic [16:0] CFetchRdy  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_010;
    localparam logic [16:0] CFetchWait = 17'b0_0_0_1_0_0_0_0_0_0_01_00_010;
    localparam logic [16:0] CDecode    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_010;
    localparam logic [16:0] CMemAdr    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [16:0] CMemRd     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_000;
    localparam logic [16:0] CMemWb     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_000;
    localparam logic [16:0] CMemWr     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_000;
    localparam logic [16:0] CExecSlt   = 17'b0_0_0_0_0_0_0_0_0_1_00_00_111;
    localparam logic [16:0] CRwb       = 17'b0_0_0_0_0_0_1_0_1_0_00_00_000;
    localparam logic [16:0] CBranch    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_110;
    localparam logic [16:0] CIExecOri  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_001;
    localparam logic [16:0] CIwbOri    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_001;
    localparam logic [16:0] CIExecAddi = 17'b0_0_0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [16:0] CIwbAddi   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_010;
    localparam logic [16:0] CJump      = 17'b1_0_0_0_0_0_0_0_0_0_00_10_000;
    localparam logic [16:0] CZero      = 17'b0;

    multicycle_control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .func          (func),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .illegal       (illegal),
        .state         (state)
    );

    assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] st, input logic [16:0] c);
        check_eq({tag, ".state"}, 32'(state), 32'(st));
        check_eq({tag, ".ctrl"}, 32'(ctrl), 32'(c));
        check_eq({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
    endtask

    // One cycle: drive inputs after the falling edge, then check outputs.
    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic r,
                       input logic [3:0] st, input logic [16:0] c, input string tag);
        @(negedge clk);
        op        = o;
        func      = f;
        mem_ready = r;
        #1;
        check_all(tag, st, c);
    endtask

    // Two reset edges; checks the first cycle after reset with mem_ready low.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_ill = 1'b0;
        #1;
        check_all(tag, 4'd0, CFetchWait);
    endtask

    initial begin
        apply_reset("reset");

        // lw with three wait cycles in MEMRD: 0,1,2,3,3,3,3,4,0
        cyc(OpLw, 6'd0, 1'b1, 4'd0, CFetchRdy, "lw.fetch");
        cyc(OpLw, 6'd0, 1'b0, 4'd1, CDecode,   "lw.decode");
        cyc(OpLw, 6'd0, 1'b0, 4'd2, CMemAdr,   "lw.memadr");
        for (int i = 0; i < 3; i++) cyc(OpLw, 6'd0, 1'b0, 4'd3, CMemRd, "lw.memrd_wait");
        cyc(OpLw, 6'd0, 1'b1, 4'd3, CMemRd,    "lw.memrd_rdy");
        cyc(OpLw, 6'd0, 1'b0, 4'd4, CMemWb,    "lw.memwb");

        // R-type slt
        cyc(OpR, FnSlt, 1'b1, 4'd0, CFetchRdy, "slt.fetch");
        cyc(OpR, FnSlt, 1'b0, 4'd1, CDecode,   "slt.decode");
        cyc(OpR, FnSlt, 1'b0, 4'd6, CExecSlt,  "slt.exec");
        cyc(OpR, FnSlt, 1'b0, 4'd7, CRwb,      "slt.rwb");

        // sw with one wait cycle; mem_write held while waiting
        cyc(OpSw, 6'd0, 1'b1, 4'd0, CFetchRdy, "sw.fetch");
        cyc(OpSw, 6'd0, 1'b0, 4'd1, CDecode,   "sw.decode");
        cyc(OpSw, 6'd0, 1'b0, 4'd2, CMemAdr,   "sw.memadr");
        cyc(OpSw, 6'd0, 1'b0, 4'd5, CMemWr,    "sw.memwr_wait");
        cyc(OpSw, 6'd0, 1'b1, 4'd5, CMemWr,    "sw.memwr_rdy");

        // beq, preceded by a fetch stall
        cyc(OpBeq, 6'd0, 1'b0, 4'd0, CFetchWait, "beq.fetch_wait");
        cyc(OpBeq, 6'd0, 1'b1, 4'd0, CFetchRdy,  "beq.fetch");
        cyc(OpBeq, 6'd0, 1'b0, 4'd1, CDecode,    "beq.decode");
        cyc(OpBeq, 6'd0, 1'b0, 4'd8, CBranch,    "beq.branch");

        // ori / addi
        cyc(OpOri, 6'd0, 1'b1, 4'd0,  CFetchRdy,  "ori.fetch");
        cyc(OpOri, 6'd0, 1'b0, 4'd1,  CDecode,    "ori.decode");
        cyc(OpOri, 6'd0, 1'b0, 4'd9,  CIExecOri,  "ori.iexec");
        cyc(OpOri, 6'd0, 1'b0, 4'd10, CIwbOri,    "ori.iwb");
        cyc(OpAddi, 6'd0, 1'b1, 4'd0,  CFetchRdy,  "addi.fetch");
        cyc(OpAddi, 6'd0, 1'b0, 4'd1,  CDecode,    "addi.decode");
        cyc(OpAddi, 6'd0, 1'b0, 4'd9,  CIExecAddi, "addi.iexec");
        cyc(OpAddi, 6'd0, 1'b0, 4'd10, CIwbAddi,   "addi.iwb");

        // j
        cyc(OpJ, 6'd0, 1'b1, 4'd0, CFetchRdy, "j.fetch");
        cyc(OpJ, 6'd0, 1'b0, 4'd1, CDecode,   "j.decode");
`ifdef MCU_JUMP_EN
        cyc(OpJ, 6'd0, 1'b0, 4'd11, CJump,     "j.jump");
        cyc(OpJ, 6'd0, 1'b0, 4'd0,  CFetchWait, "j.back");
`else
        exp_ill = 1'b1;
        cyc(OpJ, 6'd0, 1'b0, 4'd12, CZero,    "j.trap");
`endif
        apply_reset("reset_after_j");

        // R-type with an unsupported func traps
        cyc(OpR, 6'd0, 1'b1, 4'd0, CFetchRdy, "badfn.fetch");
        cyc(OpR, 6'd0, 1'b0, 4'd1, CDecode,   "badfn.decode");
        exp_ill = 1'b1;
        cyc(OpR, 6'd0, 1'b1, 4'd12, CZero,    "badfn.trap");
        apply_reset("reset_after_badfn");

        // Illegal opcode: TRAP is sticky and silent regardless of inputs
        cyc(OpBad, 6'd0, 1'b1, 4'd0, CFetchRdy, "badop.fetch");
        cyc(OpBad, 6'd0, 1'b0, 4'd1, CDecode,   "badop.decode");
        exp_ill = 1'b1;
        cyc(OpBad, 6'd0,  1'b1, 4'd12, CZero, "badop.trap");
        cyc(OpLw,  6'd0,  1'b1, 4'd12, CZero, "badop.trap_lw");
        cyc(OpR,   FnSlt, 1'b0, 4'd12, CZero, "badop.trap_slt");
        cyc(OpSw,  6'd0,  1'b1, 4'd12, CZero, "badop.trap_sw");
        apply_reset("reset_after_trap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
